systolic_array_controller: RTL and testbench
============================================

Name: systolic_array_controller

Overview:
- Wraps one systolic_array instance and sequences a complete 2×2 matrix product C = A × B. A and B are 4-bit unsigned; C is 9-bit unsigned.
- Accepts a job on a valid/ready input, then feeds the skewed operand wavefront and drives initialize.
- Waits for the array to drain, captures all four results and presents them on a valid/ready output.
- This is the top-level compute block, and the only driver of the array.

Parameters:
JOB_CNT_W, 16, width of the completed-job counter (wraps modulo 2^JOB_CNT_W)

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  reset, synchronous, active-low; also drives the array's rst_n
in_valid  in  1  job request; operands valid
in_ready  out  1  controller can accept a job (high only in IDLE)
mat_a  in  16  A: [3:0]=a11 [7:4]=a12 [11:8]=a21 [15:12]=a22
mat_b  in  16  B: same packing as mat_a
out_valid  out  1  mat_c holds a finished product
out_ready  in  1  consumer accepts mat_c
mat_c  out  36  C: [8:0]=c11 [17:9]=c12 [26:18]=c21 [35:27]=c22
busy  out  1  high in any state other than IDLE
job_count  out  JOB_CNT_W  number of completed output handshakes

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, in_ready=1, out_valid=0, mat_c=0, busy=0, job_count=0, operand registers=0, array inputs=0, initialize=0.
- Reset mid-job abandons the job; no partial result is ever presented.
- Accept: in_valid && in_ready at an edge latches mat_a/mat_b, sets state=FEED, feed_cnt=0. in_valid is ignored outside IDLE.
- FEED, feed_cnt 0..2. Array inputs are combinational from state/feed_cnt and the latched operands:
  - cnt0: a1=a11 b1=b11 a2=0 b2=0, initialize=1
  - cnt1: a1=a12 b1=b21 a2=a21 b2=b12, initialize=0
  - cnt2: a1=0 b1=0 a2=a22 b2=b22
- DRAIN: 1 cycle, all array inputs 0. The c22 accumulator completes at the end of this cycle.
- CAPTURE: 1 cycle, inputs 0. At its closing edge mat_c<={c4,c3,c2,c1}, out_valid<=1, state<=RESULT.
- RESULT: mat_c and out_valid are held stable. On out_valid && out_ready: out_valid<=0, job_count<=job_count+1 (wraps), state<=IDLE.
- Latency: out_valid rises at the 5th rising edge after the accept edge.
- Throughput: minimum 7 cycles per job with out_ready tied high.
- Array inputs are 0 in every state except FEED, and initialize is high only in FEED cnt0. This guarantees the array's internal skew registers are zero when a new FEED starts, so no residue from the previous job is picked up.
- Array accumulators keep final values between jobs; that is expected and harmless.
- Arithmetic: no overflow by construction (max 2·15·15 = 450 < 512). No saturation or truncation logic is required.
- Any state/counter encoding outside the defined set returns to IDLE on the next edge.

Decomposition:
- Package systolic_ctrl_pkg holds:
  - DATA_W=4, ACC_W=9, DIM=2, FEED_LEN=3
  - typedef enum ctrl_state_e {IDLE, FEED, DRAIN, CAPTURE, RESULT}
  - packed operand and result structs matching the port bit layouts
- Sub-module: one instance of the existing systolic_array. Inputs are fed from a small combinational mux; no other sub-modules.

Test Plan:
1. Basic product: A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> out_valid 5 edges after accept; mat_c = c11=19 c12=22 c21=43 c22=50; job_count=1.
2. Maximum values: all operands 15 -> every c field = 450. Then A=identity, B=[[2,3],[4,5]] back-to-back -> C=[[2,3],[4,5]] exactly, proving no stale accumulation or skew residue.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> mat_c stable, in_ready=0, busy=1, job_count unchanged. A new in_valid during this window is ignored. Raising out_ready gives one handshake, job_count+1, then in_ready=1 next cycle.
4. Reset mid-FEED (feed_cnt=1) -> next cycle IDLE, out_valid=0, mat_c=0, job_count=0. The next job with A=[[1,2],[3,4]], B=[[5,6],[7,8]] yields [[19,22],[43,50]].
5. Stream of 300 random jobs with random out_ready stalls -> every mat_c matches a reference multiply. job_count ends at 300 mod 2^16. Minimum spacing between accepts is 7 cycles.
6. Protocol check throughout: initialize high in exactly one cycle per job (FEED cnt0); array a/b inputs are 0 in IDLE, DRAIN, CAPTURE and RESULT.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the 2x2 systolic matrix-product controller.
// Operand/result structs mirror the packed port bit layouts.
package systolic_ctrl_pkg;

  localparam int DATA_W   = 4;
  localparam int ACC_W    = 9;
  localparam int DIM      = 2;
  localparam int FEED_LEN = 3;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    CAPTURE,
    RESULT
  } ctrl_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] e22;
    logic [DATA_W-1:0] e21;
    logic [DATA_W-1:0] e12;
    logic [DATA_W-1:0] e11;
  } mat_t;

  typedef struct packed {
    logic [ACC_W-1:0] c22;
    logic [ACC_W-1:0] c21;
    logic [ACC_W-1:0] c12;
    logic [ACC_W-1:0] c11;
  } res_t;

  // Multiply-accumulate; clr starts a fresh sum with this product.
  function automatic logic [ACC_W-1:0] mac(
    input logic [ACC_W-1:0]  acc,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              clr
  );
    logic [ACC_W-1:0] p;
    p = ACC_W'(a) * ACC_W'(b);
    return clr ? p : acc + p;
  endfunction

endpackage

// File: rtl/systolic_array.sv
// 2x2 output-stationary systolic array: a flows right, b flows down.
// initialize restarts every accumulator with the current product.
module systolic_array
  import systolic_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       initialize_i,
  input  logic [DIM*DATA_W-1:0]      a_i,
  input  logic [DIM*DATA_W-1:0]      b_i,
  output logic [DIM*DIM*ACC_W-1:0]   c_o
);

  logic [DATA_W-1:0] a1, a2, b1, b2;
  logic [DATA_W-1:0] a1_q, a2_q, b1_q, b2_q;
  logic [ACC_W-1:0]  c11_q, c12_q, c21_q, c22_q;

  assign a1 = a_i[DATA_W-1:0];
  assign a2 = a_i[2*DATA_W-1:DATA_W];
  assign b1 = b_i[DATA_W-1:0];
  assign b2 = b_i[2*DATA_W-1:DATA_W];

  // Skew registers pass operands to the neighbouring PEs one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      a1_q <= a1;
      a2_q <= a2;
      b1_q <= b1;
      b2_q <= b2;
    end
  end

  // Per-PE accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c11_q <= '0;
      c12_q <= '0;
      c21_q <= '0;
      c22_q <= '0;
    end else begin
      c11_q <= mac(c11_q, a1,   b1,   initialize_i);
      c12_q <= mac(c12_q, a1_q, b2,   initialize_i);
      c21_q <= mac(c21_q, a2,   b1_q, initialize_i);
      c22_q <= mac(c22_q, a2_q, b2_q, initialize_i);
    end
  end

  assign c_o = {c22_q, c21_q, c12_q, c11_q};

endmodule

// File: rtl/systolic_array_controller.sv
// Sequences a 2x2 product through the systolic array:
// accept, skewed feed, drain, capture, hold result until taken.
module systolic_array_controller
  import systolic_ctrl_pkg::*;
#(
  parameter int JOB_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIM*DIM*DATA_W-1:0]  mat_a,
  input  logic [DIM*DIM*DATA_W-1:0]  mat_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM*DIM*ACC_W-1:0]   mat_c,
  output logic                       busy,
  output logic [JOB_CNT_W-1:0]       job_count
);

  localparam logic [1:0] LAST_CNT = 2'(FEED_LEN - 1);

  ctrl_state_e           state_q, state_d;
  logic [1:0]            feed_cnt_q, feed_cnt_d;
  mat_t                  a_q, a_d, b_q, b_d;
  res_t                  c_q, c_d;
  logic                  ov_q, ov_d;
  logic [JOB_CNT_W-1:0]  jc_q, jc_d;

  logic [DIM*DATA_W-1:0]    arr_a, arr_b;
  logic                     arr_init;
  logic [DIM*DIM*ACC_W-1:0] arr_c;

  systolic_array u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .initialize_i (arr_init),
    .a_i          (arr_a),
    .b_i          (arr_b),
    .c_o          (arr_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      feed_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      ov_q       <= 1'b0;
      jc_q       <= '0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      ov_q       <= ov_d;
      jc_q       <= jc_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    ov_d       = ov_q;
    jc_d       = jc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = mat_t'(mat_a);
          b_d        = mat_t'(mat_b);
          feed_cnt_d = '0;
          state_d    = FEED;
        end
      end
      FEED: begin
        if (feed_cnt_q == LAST_CNT) begin
          feed_cnt_d = '0;
          state_d    = DRAIN;
        end else if (feed_cnt_q < LAST_CNT) begin
          feed_cnt_d = feed_cnt_q + 2'd1;
        end else begin
          feed_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        c_d     = res_t'(arr_c);
        ov_d    = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          jc_d    = jc_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ov_d       = 1'b0;
        feed_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Skewed operand wavefront; zero outside FEED keeps skew regs clean.
  always_comb begin
    arr_a    = '0;
    arr_b    = '0;
    arr_init = 1'b0;
    if (state_q == FEED) begin
      case (feed_cnt_q)
        2'd0: begin
          arr_a    = {{DATA_W{1'b0}}, a_q.e11};
          arr_b    = {{DATA_W{1'b0}}, b_q.e11};
          arr_init = 1'b1;
        end
        2'd1: begin
          arr_a = {a_q.e21, a_q.e12};
          arr_b = {b_q.e12, b_q.e21};
        end
        2'd2: begin
          arr_a = {a_q.e22, {DATA_W{1'b0}}};
          arr_b = {b_q.e22, {DATA_W{1'b0}}};
        end
        default: begin
          arr_a = '0;
          arr_b = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign mat_c     = c_q;
  assign job_count = jc_q;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Scoreboard bench for systolic_array_controller.
// Expected products are queued at accept and compared at each output handshake.
module tb_systolic_array_controller;

  localparam int JW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   mat_a = '0;
  logic [15:0]   mat_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [35:0]   mat_c;
  logic          busy;
  logic [JW-1:0] job_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -100;
  int n_acc = 0;
  int n_init = 0;
  int n_viol = 0;
  logic [35:0] exp_q[$];
  int at_q[$];
  logic [JW-1:0] jc_m = '0;
  logic ov_d = 1'b0;
  bit rnd_rdy = 1'b0;

  localparam logic [35:0] C_BASIC = {9'd50, 9'd43, 9'd22, 9'd19};
  localparam logic [35:0] C_MAX   = {9'd450, 9'd450, 9'd450, 9'd450};
  localparam logic [35:0] C_IDB   = {9'd5, 9'd4, 9'd3, 9'd2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_array_controller #(.JOB_CNT_W(JW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mat_c     (mat_c),
    .busy      (busy),
    .job_count (job_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
    int x[4];
    int y[4];
    int c11, c12, c21, c22;
    for (int k = 0; k < 4; k++) begin
      x[k] = int'(a[4*k +: 4]);
      y[k] = int'(b[4*k +: 4]);
    end
    c11 = x[0] * y[0] + x[1] * y[2];
    c12 = x[0] * y[1] + x[1] * y[3];
    c21 = x[2] * y[0] + x[3] * y[2];
    c22 = x[2] * y[1] + x[3] * y[3];
    return {9'(c22), 9'(c21), 9'(c12), 9'(c11)};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [35:0] e);
    int t;
    t = 0;
    mat_a = a;
    mat_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (last_acc >= 0) chk("spacing_ge7", 64'((cyc - last_acc) >= 7), 1);
    last_acc = cyc;
    n_acc++;
    exp_q.push_back(e);
    at_q.push_back(cyc);
  endtask

  task automatic wait_drain(input int lim);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    at_q.delete();
    last_acc = -100;
    jc_m = '0;
    @(posedge clk);
    #1;
  endtask

  // Output monitor: protocol checks, latency, scoreboard compare.
  always @(negedge clk) begin
    int ph;
    if (rst_n) begin
      ph = cyc - last_acc;
      if (dut.arr_init) n_init++;
      if (dut.arr_init && ph != 0) n_viol++;
      if ((dut.arr_a != 0 || dut.arr_b != 0) &&
          (!busy || out_valid || ph >= 3)) n_viol++;
      if (out_valid && !ov_d) begin
        if (at_q.size() == 0) chk("latency_noacc", 1, 0);
        else chk("latency", 64'(cyc - at_q.pop_front()), 5);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("mat_c", mat_c, exp_q.pop_front());
        chk("job_count_pre", job_count, jc_m);
        jc_m = jc_m + 1'b1;
      end
      ov_d = out_valid;
    end else begin
      ov_d = 1'b0;
    end
  end

  // Random output backpressure during the stream test.
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int t;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mat_c", mat_c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_count", job_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic product
    out_ready = 1'b1;
    send(16'h4321, 16'h8765, C_BASIC);
    wait_drain(50);
    chk("t1_job_count", job_count, 1);

    // Max values, then identity back-to-back
    send(16'hFFFF, 16'hFFFF, C_MAX);
    send(16'h1001, 16'h5432, C_IDB);
    wait_drain(50);

    // Backpressure
    out_ready = 1'b0;
    send(16'h4321, 16'h8765, C_BASIC);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b1;
    mat_a = 16'hFFFF;
    mat_b = 16'hFFFF;
    repeat (10) begin
      @(negedge clk);
      chk("bp_mat_c", mat_c, C_BASIC);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_job_count", job_count, jc_m);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_in_ready", in_ready, 1);
    chk("bp_after_out_valid", out_valid, 0);
    chk("bp_after_job_count", job_count, jc_m);
    chk("bp_sb_empty", 64'(exp_q.size()), 0);

    // Reset mid-FEED (feed_cnt=1)
    send(16'h4321, 16'h8765, C_BASIC);
    @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    at_q.delete();
    last_acc = -100;
    jc_m = '0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_mat_c", mat_c, 0);
    chk("mid_rst_job_count", job_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h4321, 16'h8765, C_BASIC);
    wait_drain(50);
    chk("mid_after_job_count", job_count, 1);

    // Random stream with stalls
    do_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send(ra, rb, ref_mul(ra, rb));
    end
    wait_drain(400);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_job_count", job_count, 300);
    chk("stream_idle", busy, 0);
    chk("init_pulses", 64'(n_init), 64'(n_acc));
    chk("proto_viol", 64'(n_viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
